// File: rtl/flag_ctrl_pkg.sv
// Shared definitions for the flag-select mux controller.
// Holds the controller state encoding, mux select codes, the default flag
// width and the settle counter width.
package flag_ctrl_pkg;

    localparam int unsigned FLAG_W_DEF = 4;
    localparam int unsigned CNT_W      = 4;

    // Mux select codes: 0 routes unit A, 1 routes unit B.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/flag_mux_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (purely combinational).
// Ports:
//   eff_a, eff_b  - effective requests from units A and B
//   last_grant    - source granted most recently (held by the caller)
//   grant_valid   - at least one request present
//   grant_id      - winning source (SEL_A / SEL_B)
module rr_arb2
    import flag_ctrl_pkg::*;
(
    input  logic eff_a,
    input  logic eff_b,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = eff_a | eff_b;
        grant_id    = SEL_A;
        if (eff_a && eff_b) begin
            // Tie goes to whichever source was not served last.
            grant_id = ~last_grant;
        end else if (eff_b) begin
            grant_id = SEL_B;
        end
    end

endmodule

// File: rtl/flag_mux_ctrl.sv
// Controller sharing one flag-select mux between arithmetic units A and B.
// Arbitrates round-robin, drives the registered mux select, waits SETTLE
// cycles, then captures the mux output (plain or sticky) and acknowledges
// the winning unit.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   req_a, req_b       - single-cycle "flags valid" pulses from A / B
//   flags_mux          - flag mux output (combinational from sel)
//   clr_flags          - synchronous clear of flag_q
//   sel                - mux select (0 = A, 1 = B), registered
//   flag_q             - captured flags
//   flag_valid         - one-cycle pulse after each capture
//   ack_a, ack_b       - one-cycle acknowledges
//   busy               - controller not idle
//   overrun            - one-cycle pulse when a request is dropped
module flag_mux_ctrl
    import flag_ctrl_pkg::*;
#(
    parameter int unsigned FLAG_W = FLAG_W_DEF,
    parameter int unsigned SETTLE = 1,
    parameter bit          STICKY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [FLAG_W-1:0] flags_mux,
    input  logic              clr_flags,
    output logic              sel,
    output logic [FLAG_W-1:0] flag_q,
    output logic              flag_valid,
    output logic              ack_a,
    output logic              ack_b,
    output logic              busy,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               pend_a_q, pend_a_d;
    logic               pend_b_q, pend_b_d;
    logic               sel_d;
    logic [FLAG_W-1:0]  flag_d;
    logic               valid_d, ack_a_d, ack_b_d, overrun_d;

    logic eff_a, eff_b;
    logic grant_valid, grant_id;
    logic settling, can_arb;
    logic drop_a, drop_b;
    logic granted_a, granted_b;

    assign eff_a = req_a | pend_a_q;
    assign eff_b = req_b | pend_b_q;

    rr_arb2 u_arb (
        .eff_a       (eff_a),
        .eff_b       (eff_b),
        .last_grant  (last_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign busy     = (state_q != ST_IDLE);
    assign settling = (state_q == ST_SETTLE);
    assign can_arb  = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // A request is lost if one is already pending for that unit, or if that
    // unit is the one currently being settled/captured.
    assign drop_a = req_a && (pend_a_q || (settling && sel == SEL_A));
    assign drop_b = req_b && (pend_b_q || (settling && sel == SEL_B));

    assign granted_a = can_arb && grant_valid && (grant_id == SEL_A);
    assign granted_b = can_arb && grant_valid && (grant_id == SEL_B);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        sel_d     = sel;
        flag_d    = flag_q;
        valid_d   = 1'b0;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        overrun_d = drop_a | drop_b;
        pend_a_d  = pend_a_q;
        pend_b_d  = pend_b_q;

        if (clr_flags) begin
            flag_d = '0;
        end

        if (req_a && !drop_a && !granted_a) pend_a_d = 1'b1;
        if (req_b && !drop_b && !granted_b) pend_b_d = 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (grant_valid) begin
                    sel_d   = grant_id;
                    last_d  = grant_id;
                    cnt_d   = CNT_INIT;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    // A coinciding clear wins over the sticky OR: the fresh
                    // capture replaces the old value outright.
                    if (STICKY && !clr_flags) begin
                        flag_d = flag_q | flags_mux;
                    end else begin
                        flag_d = flags_mux;
                    end
                    valid_d = 1'b1;
                    if (sel == SEL_A) begin
                        ack_a_d  = 1'b1;
                        pend_a_d = 1'b0;
                    end else begin
                        ack_b_d  = 1'b1;
                        pend_b_d = 1'b0;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_q     <= SEL_B;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            sel        <= SEL_A;
            flag_q     <= '0;
            flag_valid <= 1'b0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            sel        <= sel_d;
            flag_q     <= flag_d;
            flag_valid <= valid_d;
            ack_a      <= ack_a_d;
            ack_b      <= ack_b_d;
            overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_flag_mux_ctrl.sv
// Bench for flag_mux_ctrl. Three instances share the stimulus:
//   dut0: SETTLE=1 STICKY=0, dut1: SETTLE=3 STICKY=0, dut2: SETTLE=1 STICKY=1.
// The external flag mux is modelled per instance from its own sel.
module tb_flag_mux_ctrl;

    logic       clk = 1'b0;
    logic       reset, req_a, req_b, clr;
    logic [3:0] fa, fb;
    logic [2:0] sel_o, valid_o, acka_o, ackb_o, busy_o, ovr_o;
    logic [3:0] fq_o  [3];
    logic [3:0] mux_o [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mux_o[0] = sel_o[0] ? fb : fa;
    assign mux_o[1] = sel_o[1] ? fb : fa;
    assign mux_o[2] = sel_o[2] ? fb : fa;

    flag_mux_ctrl #(.FLAG_W(4), .SETTLE(1), .STICKY(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .flags_mux(mux_o[0]), .clr_flags(clr), .sel(sel_o[0]), .flag_q(fq_o[0]),
        .flag_valid(valid_o[0]), .ack_a(acka_o[0]), .ack_b(ackb_o[0]),
        .busy(busy_o[0]), .overrun(ovr_o[0]));

    flag_mux_ctrl #(.FLAG_W(4), .SETTLE(3), .STICKY(1'b0)) dut1 (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .flags_mux(mux_o[1]), .clr_flags(clr), .sel(sel_o[1]), .flag_q(fq_o[1]),
        .flag_valid(valid_o[1]), .ack_a(acka_o[1]), .ack_b(ackb_o[1]),
        .busy(busy_o[1]), .overrun(ovr_o[1]));

    flag_mux_ctrl #(.FLAG_W(4), .SETTLE(1), .STICKY(1'b1)) dut2 (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .flags_mux(mux_o[2]), .clr_flags(clr), .sel(sel_o[2]), .flag_q(fq_o[2]),
        .flag_valid(valid_o[2]), .ack_a(acka_o[2]), .ack_b(ackb_o[2]),
        .busy(busy_o[2]), .overrun(ovr_o[2]));

    // ---------------- reference model (transaction view) ----------------
    int unsigned m_settle [3] = '{1, 3, 1};
    bit          m_sticky [3] = '{1'b0, 1'b0, 1'b1};
    int          m_left   [3];   // settle cycles still to run; 0 = not settling
    bit          m_done   [3];
    bit          m_src    [3];
    bit          m_last   [3];
    bit          m_pend   [3][2];
    bit          m_ack    [3][2];
    bit          m_valid  [3];
    bit          m_ovr    [3];
    logic [3:0]  m_flag   [3];

    function automatic void model_step(int d, bit rst, bit ra, bit rb, bit cl,
                                       logic [3:0] a, logic [3:0] b);
        bit req [2];
        bit keep [2];
        bit want [2];
        bit settling;
        int w;
        int other;
        logic [3:0] mux;
        if (rst) begin
            m_left[d] = 0; m_done[d] = 0; m_src[d] = 0; m_last[d] = 1;
            m_pend[d][0] = 0; m_pend[d][1] = 0; m_ack[d][0] = 0; m_ack[d][1] = 0;
            m_valid[d] = 0; m_ovr[d] = 0; m_flag[d] = 4'b0000;
            return;
        end
        req[0] = ra; req[1] = rb;
        settling = (m_left[d] > 0);
        mux = m_src[d] ? b : a;
        m_ovr[d] = 0; m_valid[d] = 0; m_done[d] = 0;
        m_ack[d][0] = 0; m_ack[d][1] = 0;
        for (int x = 0; x < 2; x++) begin
            keep[x] = req[x];
            if (req[x] && (m_pend[d][x] || (settling && int'(m_src[d]) == x))) begin
                keep[x] = 0;
                m_ovr[d] = 1;
            end
        end
        if (settling) begin
            other = m_src[d] ? 0 : 1;
            if (keep[other]) m_pend[d][other] = 1;
            m_left[d]--;
            if (m_left[d] == 0) begin
                if (cl || !m_sticky[d]) m_flag[d] = mux;
                else m_flag[d] = m_flag[d] | mux;
                m_ack[d][m_src[d]] = 1;
                m_valid[d] = 1;
                m_pend[d][m_src[d]] = 0;
                m_done[d] = 1;
            end else if (cl) begin
                m_flag[d] = 4'b0000;
            end
        end else begin
            if (cl) m_flag[d] = 4'b0000;
            for (int x = 0; x < 2; x++) want[x] = keep[x] | m_pend[d][x];
            if (want[0] || want[1]) begin
                w = (want[0] && want[1]) ? (m_last[d] ? 0 : 1) : (want[1] ? 1 : 0);
                m_src[d] = w[0];
                m_last[d] = w[0];
                m_left[d] = int'(m_settle[d]);
                other = w ? 0 : 1;
                if (keep[other]) m_pend[d][other] = 1;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; clr = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; req_a = 1'b1; req_b = 1'b1; clr = 1'b0; fa = 4'hF; fb = 4'hF;
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({sel_o[d], valid_o[d], acka_o[d], ackb_o[d], busy_o[d], ovr_o[d], fq_o[d]} !== 10'b0) begin
                errors++;
                $display("FAIL reset_dut%0d got sel=%b v=%b aa=%b ab=%b busy=%b ovr=%b fq=%b exp all 0",
                         d, sel_o[d], valid_o[d], acka_o[d], ackb_o[d], busy_o[d], ovr_o[d], fq_o[d]);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        fa = 4'b1010; fb = 4'b0000; req_a = 1'b1;
        tick(); req_a = 1'b0;
        checks++; if (sel_o[0] !== 1'b0 || busy_o[0] !== 1'b1 || acka_o[0] !== 1'b0) begin errors++;
            $display("FAIL single_c1 got sel=%b busy=%b ack_a=%b exp 0 1 0", sel_o[0], busy_o[0], acka_o[0]); end
        tick();
        checks++; if (acka_o[0] !== 1'b1 || valid_o[0] !== 1'b1 || fq_o[0] !== 4'b1010) begin errors++;
            $display("FAIL single_c2 got ack_a=%b valid=%b fq=%b exp 1 1 1010", acka_o[0], valid_o[0], fq_o[0]); end
        tick();
        checks++; if (busy_o[0] !== 1'b0 || acka_o[0] !== 1'b0 || valid_o[0] !== 1'b0) begin errors++;
            $display("FAIL single_c3 got busy=%b ack_a=%b valid=%b exp 0 0 0", busy_o[0], acka_o[0], valid_o[0]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fa = 4'b0001; fb = 4'b1000; req_a = 1'b1; req_b = 1'b1;
        tick(); req_a = 1'b0; req_b = 1'b0;
        checks++; if (sel_o[0] !== 1'b0) begin errors++; $display("FAIL pair_c1_sel got %b exp 0", sel_o[0]); end
        tick();
        checks++; if (acka_o[0] !== 1'b1 || ackb_o[0] !== 1'b0 || fq_o[0] !== 4'b0001) begin errors++;
            $display("FAIL pair_c2 got ack_a=%b ack_b=%b fq=%b exp 1 0 0001", acka_o[0], ackb_o[0], fq_o[0]); end
        tick();
        checks++; if (sel_o[0] !== 1'b1 || acka_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin errors++;
            $display("FAIL pair_c3 got sel=%b ack_a=%b busy=%b exp 1 0 1", sel_o[0], acka_o[0], busy_o[0]); end
        tick();
        checks++; if (ackb_o[0] !== 1'b1 || fq_o[0] !== 4'b1000) begin errors++;
            $display("FAIL pair_c4 got ack_b=%b fq=%b exp 1 1000", ackb_o[0], fq_o[0]); end
        tick();
        // single A leaves A as last grant; the next tie must go to B
        req_a = 1'b1;
        tick(); req_a = 1'b0;
        tick();
        tick();
        req_a = 1'b1; req_b = 1'b1;
        tick(); req_a = 1'b0; req_b = 1'b0;
        checks++; if (sel_o[0] !== 1'b1) begin errors++; $display("FAIL pair2_first_sel got %b exp 1", sel_o[0]); end
        tick();
        checks++; if (ackb_o[0] !== 1'b1 || acka_o[0] !== 1'b0) begin errors++;
            $display("FAIL pair2_ack_b got ack_b=%b ack_a=%b exp 1 0", ackb_o[0], acka_o[0]); end
        tick();
        tick();
        checks++; if (acka_o[0] !== 1'b1 || fq_o[0] !== 4'b0001) begin errors++;
            $display("FAIL pair2_ack_a got ack_a=%b fq=%b exp 1 0001", acka_o[0], fq_o[0]); end
        tick();
    endtask

    task automatic test_sticky();
        do_reset();
        fa = 4'b0011; fb = 4'b0100; req_a = 1'b1;
        tick(); req_a = 1'b0;
        tick();
        checks++; if (fq_o[2] !== 4'b0011) begin errors++; $display("FAIL sticky_a got %b exp 0011", fq_o[2]); end
        tick();
        req_b = 1'b1;
        tick(); req_b = 1'b0;
        tick();
        checks++; if (fq_o[2] !== 4'b0111) begin errors++; $display("FAIL sticky_or got %b exp 0111", fq_o[2]); end
        checks++; if (fq_o[0] !== 4'b0100) begin errors++; $display("FAIL plain_overwrite got %b exp 0100", fq_o[0]); end
        clr = 1'b1;
        tick(); clr = 1'b0;
        checks++; if (fq_o[2] !== 4'b0000) begin errors++; $display("FAIL sticky_clr got %b exp 0000", fq_o[2]); end
        req_b = 1'b1;
        tick(); req_b = 1'b0;
        tick();
        checks++; if (fq_o[2] !== 4'b0100) begin errors++; $display("FAIL sticky_b2 got %b exp 0100", fq_o[2]); end
        // request during DONE goes straight back to SETTLE; clear on its capture edge
        fa = 4'b1000; req_a = 1'b1;
        tick(); req_a = 1'b0; clr = 1'b1;
        tick(); clr = 1'b0;
        checks++; if (fq_o[2] !== 4'b1000 || acka_o[2] !== 1'b1) begin errors++;
            $display("FAIL sticky_clr_capture got fq=%b ack_a=%b exp 1000 1", fq_o[2], acka_o[2]); end
        tick();
    endtask

    task automatic test_settle3();
        do_reset();
        fa = 4'b0000; fb = 4'b1111; req_b = 1'b1;
        tick(); req_b = 1'b0;
        checks++; if (sel_o[1] !== 1'b1) begin errors++; $display("FAIL s3_c1_sel got %b exp 1", sel_o[1]); end
        tick();
        checks++; if (sel_o[1] !== 1'b1 || ackb_o[1] !== 1'b0) begin errors++;
            $display("FAIL s3_c2 got sel=%b ack_b=%b exp 1 0", sel_o[1], ackb_o[1]); end
        fb = 4'b0110;
        tick();
        checks++; if (sel_o[1] !== 1'b1 || ackb_o[1] !== 1'b0 || busy_o[1] !== 1'b1) begin errors++;
            $display("FAIL s3_c3 got sel=%b ack_b=%b busy=%b exp 1 0 1", sel_o[1], ackb_o[1], busy_o[1]); end
        tick();
        checks++; if (ackb_o[1] !== 1'b1 || acka_o[1] !== 1'b0 || fq_o[1] !== 4'b0110) begin errors++;
            $display("FAIL s3_c4 got ack_b=%b ack_a=%b fq=%b exp 1 0 0110", ackb_o[1], acka_o[1], fq_o[1]); end
        tick();
        checks++; if (busy_o[1] !== 1'b0) begin errors++; $display("FAIL s3_idle got busy=%b exp 0", busy_o[1]); end
    endtask

    task automatic test_overrun();
        do_reset();
        fa = 4'b0101; fb = 4'b0000; req_a = 1'b1;
        tick();
        checks++; if (ovr_o[0] !== 1'b0) begin errors++; $display("FAIL ovr_c1 got %b exp 0", ovr_o[0]); end
        tick(); req_a = 1'b1;
        checks++; if (ovr_o[0] !== 1'b1 || acka_o[0] !== 1'b1) begin errors++;
            $display("FAIL ovr_c2 got ovr=%b ack_a=%b exp 1 1", ovr_o[0], acka_o[0]); end
        tick(); req_a = 1'b0;
        checks++; if (ovr_o[0] !== 1'b0 || busy_o[0] !== 1'b1 || acka_o[0] !== 1'b0) begin errors++;
            $display("FAIL ovr_c3 got ovr=%b busy=%b ack_a=%b exp 0 1 0", ovr_o[0], busy_o[0], acka_o[0]); end
        tick();
        checks++; if (acka_o[0] !== 1'b1 || ovr_o[0] !== 1'b0) begin errors++;
            $display("FAIL ovr_c4 got ack_a=%b ovr=%b exp 1 0", acka_o[0], ovr_o[0]); end
        tick();
        checks++; if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL ovr_c5 got busy=%b exp 0", busy_o[0]); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        fa = 4'b1100; fb = 4'b0011; req_a = 1'b1; req_b = 1'b1;
        tick(); req_a = 1'b0; req_b = 1'b0; reset = 1'b1;
        checks++; if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b exp 1", busy_o[0]); end
        tick(); reset = 1'b0;
        checks++; if ({sel_o[0], valid_o[0], acka_o[0], ackb_o[0], busy_o[0], ovr_o[0], fq_o[0]} !== 10'b0) begin
            errors++;
            $display("FAIL rmid_zero got sel=%b v=%b aa=%b ab=%b busy=%b ovr=%b fq=%b exp all 0",
                     sel_o[0], valid_o[0], acka_o[0], ackb_o[0], busy_o[0], ovr_o[0], fq_o[0]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (acka_o[0] !== 1'b0 || ackb_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin errors++;
                $display("FAIL rmid_noack%0d got ack_a=%b ack_b=%b busy=%b exp 0 0 0", i, acka_o[0], ackb_o[0], busy_o[0]); end
        end
        req_a = 1'b1; req_b = 1'b1;
        tick(); req_a = 1'b0; req_b = 1'b0;
        tick();
        checks++; if (acka_o[0] !== 1'b1 || ackb_o[0] !== 1'b0) begin errors++;
            $display("FAIL rmid_tie got ack_a=%b ack_b=%b exp 1 0", acka_o[0], ackb_o[0]); end
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        logic [9:0] exp_v, got_v;
        bit busy_e;
        for (int n = 0; n < 1500; n++) begin
            reset = (n == 0) || ($urandom_range(0, 199) == 0);
            req_a = ($urandom_range(0, 2) == 0);
            req_b = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 15) == 0);
            fa    = 4'($urandom);
            fb    = 4'($urandom);
            for (int d = 0; d < 3; d++) model_step(d, reset, req_a, req_b, clr, fa, fb);
            tick();
            for (int d = 0; d < 3; d++) begin
                busy_e = (m_left[d] > 0) || m_done[d];
                exp_v = {m_src[d], m_valid[d], m_ack[d][0], m_ack[d][1], busy_e, m_ovr[d], m_flag[d]};
                got_v = {sel_o[d], valid_o[d], acka_o[d], ackb_o[d], busy_o[d], ovr_o[d], fq_o[d]};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL rand_n%0d_dut%0d got sel,v,aa,ab,busy,ovr,fq=%b exp %b", n, d, got_v, exp_v);
                end
            end
        end
        reset = 1'b0; req_a = 1'b0; req_b = 1'b0; clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; clr = 1'b0; fa = 4'b0; fb = 4'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_sticky();
        test_settle3();
        test_overrun();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
